// File: rtl/scr1_tapc_dmi_chain_ctrl.sv
// DMI/DTMCS scan-chain controller in the SysCLK domain. Update to request is 1 cycle. A request is held until dmi_resp_i arrives.
// If SCR1_TAPC_DMI_TIMEOUT_EN is defined, a request with no response for TIMEOUT_CYC cycles is abandoned.
module scr1_tapc_dmi_chain_ctrl #(
   parameter int DMI_ADDR_W  = 7,
   parameter int DMI_DATA_W  = 32,
   parameter int CH_ID_W     = 2,
   parameter int CH_ID_DMI   = 1,
   parameter int CH_ID_DTMCS = 0,
   parameter int TIMEOUT_CYC = 1023
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ch_sel_i,
   input  logic [CH_ID_W-1:0]    ch_id_i,
   input  logic                  capture_i,
   input  logic                  shift_i,
   input  logic                  update_i,
   input  logic                  tdi_i,
   output logic                  tdo_o,
   output logic                  dmi_req_o,
   output logic                  dmi_wr_o,
   output logic [DMI_ADDR_W-1:0] dmi_addr_o,
   output logic [DMI_DATA_W-1:0] dmi_wdata_o,
   input  logic                  dmi_resp_i,
   input  logic [DMI_DATA_W-1:0] dmi_rdata_i,
   output logic                  busy_o
);

   localparam int ACC_W = DMI_ADDR_W + DMI_DATA_W + 2;
   localparam logic [5:0] ABITS = 6'(DMI_ADDR_W);

   typedef enum logic {ST_IDLE, ST_REQ} state_t;
   state_t state, state_nxt;

   logic [ACC_W-1:0]      acc_sr;
   logic [31:0]           dtm_sr;
   logic [DMI_ADDR_W-1:0] last_addr;
   logic [DMI_DATA_W-1:0] last_rdata;
   logic [DMI_DATA_W-1:0] wdata;
   logic                  wr;
   logic [1:0]            dmistat, dmistat_nxt;
   logic                  sel_dmi, sel_dtm;
   logic                  cap, shf, upd;
   logic                  req_start, resp_take;
   logic                  to_expired;
   logic [1:0]            upd_op;
   logic [DMI_ADDR_W-1:0] upd_addr;
   logic [DMI_DATA_W-1:0] upd_data;

   assign sel_dmi  = ch_sel_i & (ch_id_i == CH_ID_W'(CH_ID_DMI));
   assign sel_dtm  = ch_sel_i & (ch_id_i == CH_ID_W'(CH_ID_DTMCS)) & ~sel_dmi;
   // Capture has priority over any other strobe that coincides with it.
   assign cap      = capture_i;
   assign shf      = shift_i & ~capture_i;
   assign upd      = update_i & ~capture_i & ~shift_i;
   assign upd_op   = acc_sr[1:0];
   assign upd_data = acc_sr[DMI_DATA_W+1:2];
   assign upd_addr = acc_sr[ACC_W-1:DMI_DATA_W+2];

`ifdef SCR1_TAPC_DMI_TIMEOUT_EN
   localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
   logic [TO_W-1:0] to_cnt;
   assign to_expired = (to_cnt == TO_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)               to_cnt <= '0;
      else if (state != ST_REQ) to_cnt <= '0;
      else                      to_cnt <= to_cnt + TO_W'(1);
   end
`else
   assign to_expired = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      dmistat_nxt = dmistat;
      req_start   = 1'b0;
      resp_take   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (upd && sel_dmi && (dmistat == 2'd0) && ((upd_op == 2'd1) || (upd_op == 2'd2))) begin
               state_nxt = ST_REQ;
               req_start = 1'b1;
            end
         end
         ST_REQ: begin
            if (dmi_resp_i) begin
               state_nxt = ST_IDLE;
               resp_take = 1'b1;
            end else if (to_expired) begin
               state_nxt   = ST_IDLE;
               dmistat_nxt = 2'd2;
            end
            if (upd && sel_dmi) dmistat_nxt = 2'd3;
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (upd && sel_dtm && (dtm_sr[16] || dtm_sr[17])) dmistat_nxt = 2'd0;
      // Hard reset abandons the transaction; a response arriving now or later is dropped.
      if (upd && sel_dtm && dtm_sr[17]) begin
         state_nxt = ST_IDLE;
         resp_take = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_sr     <= '0;
         dtm_sr     <= '0;
         last_addr  <= '0;
         last_rdata <= '0;
         wdata      <= '0;
         wr         <= 1'b0;
         dmistat    <= 2'd0;
      end else begin
         dmistat <= dmistat_nxt;
         if (cap && sel_dmi)
            acc_sr <= {last_addr, last_rdata, (state == ST_REQ) ? 2'd3 : dmistat};
         else if (shf && sel_dmi)
            acc_sr <= {tdi_i, acc_sr[ACC_W-1:1]};
         if (cap && sel_dtm)
            dtm_sr <= {14'd0, 2'b00, 1'b0, 3'd0, dmistat, ABITS, 4'd1};
         else if (shf && sel_dtm)
            dtm_sr <= {tdi_i, dtm_sr[31:1]};
         if (req_start) begin
            last_addr <= upd_addr;
            wdata     <= upd_data;
            wr        <= upd_op[1];
         end
         if (resp_take && !wr) last_rdata <= dmi_rdata_i;
      end
   end

   assign tdo_o       = sel_dmi ? acc_sr[0] : (sel_dtm ? dtm_sr[0] : 1'b0);
   assign dmi_req_o   = (state == ST_REQ);
   assign busy_o      = (state == ST_REQ);
   assign dmi_wr_o    = wr;
   assign dmi_addr_o  = last_addr;
   assign dmi_wdata_o = wdata;

endmodule
